// File: rtl/sdram_responder.sv
// sdram_responder: target end of a 32-bit SDR SDRAM command bus.
// Decodes RAS/CAS/WE commands, keeps per-bank open rows and the mode register,
// and serves sequential, wrapping bursts from an internal word array.
// Read data runs through a CL-deep pipeline.
module sdram_responder #(
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 8
) (
  input  logic        MainClk,
  input  logic        ResetN,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic        cke,
  input  logic [1:0]  ba,
  input  logic [10:0] addr,
  input  logic [3:0]  dm,
  input  logic [31:0] dq_in,
  output logic [31:0] dq_out,
  output logic        dq_oe,
  output logic        error,
  output logic [15:0] refresh_count
);
  localparam int IDX_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_t;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         rd_data_reg;
  logic [31:0]         pipe1_data_reg;
  logic                pipe0_valid_reg;
  logic                pipe1_valid_reg;
  logic [3:0]          bank_open_reg;
  logic [ROW_BITS-1:0] bank_row_reg [4];
  logic                cl3_reg;
  logic [2:0]          bl_mask_reg;
  logic                burst_active_reg;
  logic                burst_wr_reg;
  logic                burst_ap_reg;
  logic [1:0]          burst_bank_reg;
  logic [COL_BITS-1:0] burst_col_reg;
  logic [2:0]          burst_cnt_reg;

  cmd_t                cmd;
  logic                any_open;
  logic                bank_hit;
  logic                rd_ok;
  logic                wr_ok;
  logic                access;
  logic                cl_legal;
  logic                pre_hit;
  logic                term;
  logic                cont;
  logic                last_beat;
  logic                beat_rd;
  logic                beat_wr;
  logic [1:0]          beat_bank;
  logic [COL_BITS-1:0] beat_col;
  logic [COL_BITS-1:0] col_mask;
  logic [IDX_BITS-1:0] beat_idx;
  logic                unused_bits;

  // addr[9:8] carry no meaning for the modelled geometry
  assign unused_bits = ^addr[9:8];

  // Command decode and the column access selected for this edge
  always_comb begin
    cmd       = cs_n ? CMD_NOP : cmd_t'({ras_n, cas_n, we_n});
    any_open  = |bank_open_reg;
    bank_hit  = bank_open_reg[ba];
    rd_ok     = (cmd == CMD_RD) && bank_hit;
    wr_ok     = (cmd == CMD_WR) && bank_hit;
    access    = rd_ok || wr_ok;
    cl_legal  = (addr[6:4] == 3'd2) || (addr[6:4] == 3'd3);
    pre_hit   = (cmd == CMD_PRE) && (addr[10] || (ba == burst_bank_reg));
    term      = burst_active_reg && (access || (cmd == CMD_BST) || pre_hit);
    cont      = burst_active_reg && !term;
    last_beat = cont && (burst_cnt_reg == bl_mask_reg);
    col_mask  = COL_BITS'(bl_mask_reg);
    if (access) begin
      beat_bank = ba;
      beat_col  = addr[COL_BITS-1:0];
    end else begin
      // sequential order, wrapping inside the BL-aligned block
      beat_bank = burst_bank_reg;
      beat_col  = (burst_col_reg & ~col_mask) |
                  ((burst_col_reg + COL_BITS'(burst_cnt_reg)) & col_mask);
    end
    beat_idx = {beat_bank, bank_row_reg[beat_bank], beat_col};
    beat_rd  = rd_ok || (cont && !burst_wr_reg);
    beat_wr  = wr_ok || (cont && burst_wr_reg);
  end

  // Memory array: byte-masked writes and a registered read for the pipeline head
  always_ff @(posedge MainClk) begin
    if (cke) begin
      if (beat_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (!dm[i]) mem[beat_idx][8*i +: 8] <= dq_in[8*i +: 8];
        end
      end
      rd_data_reg <= mem[beat_idx];
    end
  end

  // Control: read pipeline, burst tracking, bank state, mode register, status
  always_ff @(posedge MainClk or negedge ResetN) begin
    if (!ResetN) begin
      dq_out           <= 32'h0;
      dq_oe            <= 1'b0;
      error            <= 1'b0;
      refresh_count    <= 16'h0;
      pipe0_valid_reg  <= 1'b0;
      pipe1_valid_reg  <= 1'b0;
      pipe1_data_reg   <= 32'h0;
      bank_open_reg    <= 4'b0;
      for (int b = 0; b < 4; b++) bank_row_reg[b] <= '0;
      cl3_reg          <= 1'b0;
      bl_mask_reg      <= 3'd0;
      burst_active_reg <= 1'b0;
      burst_wr_reg     <= 1'b0;
      burst_ap_reg     <= 1'b0;
      burst_bank_reg   <= 2'd0;
      burst_col_reg    <= '0;
      burst_cnt_reg    <= 3'd0;
    end else if (cke) begin
      pipe0_valid_reg <= beat_rd;
      pipe1_valid_reg <= pipe0_valid_reg;
      pipe1_data_reg  <= rd_data_reg;
      if (cl3_reg) begin
        dq_oe <= pipe1_valid_reg;
        if (pipe1_valid_reg) dq_out <= pipe1_data_reg;
      end else begin
        dq_oe <= pipe0_valid_reg;
        if (pipe0_valid_reg) dq_out <= rd_data_reg;
      end
      // a WRITE owns the bus from its own edge: drop every pending read beat
      if (wr_ok) begin
        pipe0_valid_reg <= 1'b0;
        pipe1_valid_reg <= 1'b0;
        dq_oe           <= 1'b0;
      end

      if (access) begin
        burst_wr_reg     <= wr_ok;
        burst_ap_reg     <= addr[10];
        burst_bank_reg   <= ba;
        burst_col_reg    <= addr[COL_BITS-1:0];
        burst_cnt_reg    <= 3'd1;
        burst_active_reg <= (bl_mask_reg != 3'd0);
      end else if (term) begin
        burst_active_reg <= 1'b0;
      end else if (cont) begin
        burst_cnt_reg <= burst_cnt_reg + 3'd1;
        if (last_beat) burst_active_reg <= 1'b0;
      end

      // auto-precharge fires on the last issued beat or on termination
      if (burst_ap_reg && (term || last_beat)) bank_open_reg[burst_bank_reg] <= 1'b0;
      if (access && addr[10] && (bl_mask_reg == 3'd0)) bank_open_reg[ba] <= 1'b0;

      case (cmd)
        CMD_MRS: begin
          if (any_open || !cl_legal) begin
            error <= 1'b1;
          end else begin
            cl3_reg <= (addr[6:4] == 3'd3);
            case (addr[2:0])
              3'd1:    bl_mask_reg <= 3'd1;
              3'd2:    bl_mask_reg <= 3'd3;
              3'd3:    bl_mask_reg <= 3'd7;
              default: bl_mask_reg <= 3'd0;
            endcase
          end
        end
        CMD_REF: begin
          if (any_open) error <= 1'b1;
          if (refresh_count != 16'hFFFF) refresh_count <= refresh_count + 16'd1;
        end
        CMD_PRE: begin
          if (addr[10]) bank_open_reg <= 4'b0;
          else          bank_open_reg[ba] <= 1'b0;
        end
        CMD_ACT: begin
          if (bank_hit) begin
            error <= 1'b1;
          end else begin
            bank_open_reg[ba] <= 1'b1;
            bank_row_reg[ba]  <= addr[ROW_BITS-1:0];
          end
        end
        CMD_RD, CMD_WR: begin
          if (!bank_hit) error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Testbench for sdram_responder: drives controller-side commands and checks
// read beats against a scoreboard of (data, expected cycle) entries.
module tb_sdram_responder;
  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        MainClk;
  logic        ResetN;
  logic        cs_n, ras_n, cas_n, we_n, cke;
  logic [1:0]  ba;
  logic [10:0] addr;
  logic [3:0]  dm;
  logic [31:0] dq_in;
  logic [31:0] dq_out;
  logic        dq_oe;
  logic        error;
  logic [15:0] refresh_count;

  typedef struct {
    logic [31:0] data;
    int          at;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] model_mem [int];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_edge = 0;
  beat_t       mon_e;

  sdram_responder #(.ROW_BITS(2), .COL_BITS(8)) dut (
    .MainClk(MainClk), .ResetN(ResetN), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .cke(cke), .ba(ba), .addr(addr), .dm(dm),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .error(error),
    .refresh_count(refresh_count)
  );

  initial MainClk = 1'b0;
  always #5 MainClk = ~MainClk;
  always @(posedge MainClk) cyc <= cyc + 1;

  // Monitor: every driven beat must match the head of the scoreboard in data and cycle
  always @(negedge MainClk) begin
    if (ResetN && dq_oe) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat cyc=%0d got dq_out=%h dq_oe=1 exp dq_oe=0", cyc, dq_out);
      end else begin
        mon_e = sb.pop_front();
        if (dq_out !== mon_e.data || cyc != mon_e.at) begin
          errors++;
          $display("FAIL read_beat got data=%h cyc=%0d exp data=%h cyc=%0d", dq_out, cyc, mon_e.data, mon_e.at);
        end else begin
          $display("beat cyc=%0d data=%h", cyc, dq_out);
        end
      end
    end
  end

  function automatic void model_wr(input logic [1:0] b, input logic [1:0] r,
                                   input logic [7:0] c, input logic [31:0] d,
                                   input logic [3:0] m);
    int key;
    logic [31:0] w;
    key = int'({b, r, c});
    w = model_mem.exists(key) ? model_mem[key] : 32'h0;
    for (int i = 0; i < 4; i++) if (!m[i]) w[8*i +: 8] = d[8*i +: 8];
    model_mem[key] = w;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] b, input logic [1:0] r,
                                           input logic [7:0] c);
    int key;
    key = int'({b, r, c});
    return model_mem.exists(key) ? model_mem[key] : 32'h0;
  endfunction

  function automatic logic [7:0] wrap_col(input logic [7:0] c, input int k, input int bl);
    logic [7:0] m;
    m = 8'(bl - 1);
    return (c & ~m) | ((c + 8'(k)) & m);
  endfunction

  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [10:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b; addr = a; dq_in = d; dm = m;
    @(posedge MainClk); #1;
    last_edge = cyc;
    $display("cmd=%b ba=%0d addr=%h dq_in=%h dm=%b cke=%b edge=%0d", c, b, a, d, m, cke, cyc);
    {ras_n, cas_n, we_n} = C_NOP;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 11'h0, 32'h0, 4'h0);
  endtask

  task automatic wr_burst(input logic [1:0] b, input logic [1:0] r, input logic [7:0] col,
                          input int bl, input logic [31:0] base);
    for (int k = 0; k < bl; k++) begin
      model_wr(b, r, wrap_col(col, k, bl), base + 32'(k), 4'h0);
      if (k == 0) issue(C_WR, b, {3'b000, col}, base, 4'h0);
      else        issue(C_NOP, 2'd0, 11'h0, base + 32'(k), 4'h0);
    end
  endtask

  task automatic rd_burst(input logic [1:0] b, input logic [1:0] r, input logic [7:0] col,
                          input int bl, input int cl, input int nb);
    beat_t e;
    issue(C_RD, b, {3'b000, col}, 32'h0, 4'h0);
    for (int k = 0; k < nb; k++) begin
      e.data = model_rd(b, r, wrap_col(col, k, bl));
      e.at   = last_edge + cl - 1 + k;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge MainClk);
    #1;
    checks++; if (dq_out !== 32'h0) begin errors++; $display("FAIL reset_dq_out got=%h exp=0", dq_out); end
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe got=%b exp=0", dq_oe); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (refresh_count !== 16'h0) begin errors++; $display("FAIL reset_refresh got=%h exp=0", refresh_count); end
    ResetN = 1'b1;
  endtask

  task automatic test_basic();
    beat_t e;
    issue(C_MRS, 2'd0, 11'h020, 32'h0, 4'h0);
    issue(C_ACT, 2'd1, 11'd3, 32'h0, 4'h0);
    issue(C_WR, 2'd1, 11'h010, 32'hDEADBEEF, 4'h0);
    model_wr(2'd1, 2'd3, 8'h10, 32'hDEADBEEF, 4'h0);
    issue(C_RD, 2'd1, 11'h010, 32'h0, 4'h0);
    e.data = 32'hDEADBEEF; e.at = last_edge + 1;
    sb.push_back(e);
    nop(4);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_drain got=%0d left exp=0", sb.size()); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got=%b exp=0", error); end
  endtask

  task automatic test_burst8();
    logic [31:0] exp_vals [8];
    beat_t e;
    exp_vals = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd0, 32'd1};
    issue(C_PRE, 2'd0, 11'h400, 32'h0, 4'h0);
    issue(C_MRS, 2'd0, 11'h033, 32'h0, 4'h0);
    issue(C_ACT, 2'd0, 11'd1, 32'h0, 4'h0);
    wr_burst(2'd0, 2'd1, 8'h06, 8, 32'd0);
    rd_burst(2'd0, 2'd1, 8'h06, 8, 3, 8);
    nop(12);
    // column 0 onward: wrapped write placed 2..7 at columns 0..5
    issue(C_RD, 2'd0, 11'h000, 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      e.data = exp_vals[k]; e.at = last_edge + 2 + k;
      sb.push_back(e);
    end
    nop(12);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL burst8_drain got=%0d left exp=0", sb.size()); end
  endtask

  task automatic test_partial();
    beat_t e;
    issue(C_PRE, 2'd0, 11'h400, 32'h0, 4'h0);
    issue(C_MRS, 2'd0, 11'h020, 32'h0, 4'h0);
    issue(C_ACT, 2'd2, 11'd0, 32'h0, 4'h0);
    issue(C_WR, 2'd2, 11'h030, 32'hAABBCCDD, 4'b0000);
    model_wr(2'd2, 2'd0, 8'h30, 32'hAABBCCDD, 4'b0000);
    issue(C_WR, 2'd2, 11'h030, 32'h11223344, 4'b0101);
    model_wr(2'd2, 2'd0, 8'h30, 32'h11223344, 4'b0101);
    issue(C_RD, 2'd2, 11'h030, 32'h0, 4'h0);
    e.data = 32'h11BB33DD; e.at = last_edge + 1;
    sb.push_back(e);
    nop(4);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL partial_drain got=%0d left exp=0", sb.size()); end
  endtask

  task automatic test_terminate();
    issue(C_PRE, 2'd0, 11'h400, 32'h0, 4'h0);
    issue(C_MRS, 2'd0, 11'h022, 32'h0, 4'h0);
    issue(C_ACT, 2'd0, 11'd2, 32'h0, 4'h0);
    wr_burst(2'd0, 2'd2, 8'h20, 4, 32'hA0);
    // READ then BURST TERMINATE: one beat only
    rd_burst(2'd0, 2'd2, 8'h21, 4, 2, 1);
    issue(C_BST, 2'd0, 11'h0, 32'h0, 4'h0);
    nop(5);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bst_drain got=%0d left exp=0", sb.size()); end
    // READ then WRITE: no read beat may appear
    issue(C_RD, 2'd0, 11'h020, 32'h0, 4'h0);
    wr_burst(2'd0, 2'd2, 8'h40, 4, 32'hB0);
    nop(5);
    // back-to-back reads: eight contiguous beats
    rd_burst(2'd0, 2'd2, 8'h21, 4, 2, 4);
    nop(3);
    rd_burst(2'd0, 2'd2, 8'h40, 4, 2, 4);
    nop(8);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain got=%0d left exp=0", sb.size()); end
  endtask

  task automatic test_errors();
    issue(C_PRE, 2'd0, 11'h400, 32'h0, 4'h0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_clean got=%b exp=0", error); end
    issue(C_RD, 2'd2, 11'h000, 32'h0, 4'h0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_idle_read got=%b exp=1", error); end
    nop(4);
    issue(C_ACT, 2'd0, 11'd0, 32'h0, 4'h0);
    issue(C_ACT, 2'd0, 11'd0, 32'h0, 4'h0);
    nop(2);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", error); end
    issue(C_PRE, 2'd0, 11'h400, 32'h0, 4'h0);
    issue(C_MRS, 2'd0, 11'h053, 32'h0, 4'h0);
    // mode must still be CL=2, BL=4
    issue(C_ACT, 2'd0, 11'd2, 32'h0, 4'h0);
    rd_burst(2'd0, 2'd2, 8'h20, 4, 2, 4);
    nop(8);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bad_mrs_drain got=%0d left exp=0", sb.size()); end
    ResetN = 1'b0;
    #10;
    ResetN = 1'b1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", error); end
  endtask

  task automatic test_refresh();
    for (int i = 0; i < 3; i++) issue(C_REF, 2'd0, 11'h0, 32'h0, 4'h0);
    checks++; if (refresh_count !== 16'd3) begin errors++; $display("FAIL refresh_count got=%0d exp=3", refresh_count); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL refresh_error got=%b exp=0", error); end
  endtask

  task automatic test_cke();
    beat_t e;
    int e0;
    issue(C_MRS, 2'd0, 11'h022, 32'h0, 4'h0);
    issue(C_ACT, 2'd3, 11'd1, 32'h0, 4'h0);
    wr_burst(2'd3, 2'd1, 8'h80, 4, 32'hC0);
    issue(C_RD, 2'd3, 11'h080, 32'h0, 4'h0);
    e0 = last_edge;
    e.data = 32'hC0; e.at = e0 + 1; sb.push_back(e);
    for (int i = 2; i <= 6; i++) begin e.data = 32'hC1; e.at = e0 + i; sb.push_back(e); end
    e.data = 32'hC2; e.at = e0 + 7; sb.push_back(e);
    e.data = 32'hC3; e.at = e0 + 8; sb.push_back(e);
    nop(2);
    cke = 1'b0;
    nop(4);
    checks++; if (dq_oe !== 1'b1 || dq_out !== 32'hC1) begin errors++; $display("FAIL cke_hold got oe=%b data=%h exp oe=1 data=000000c1", dq_oe, dq_out); end
    cke = 1'b1;
    nop(5);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL cke_drain got=%0d left exp=0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    beat_t e;
    rd_burst(2'd3, 2'd1, 8'h80, 4, 2, 4);
    nop(2);
    ResetN = 1'b0;
    sb.delete();
    #1;
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe got=%b exp=0", dq_oe); end
    checks++; if (dq_out !== 32'h0) begin errors++; $display("FAIL rst_mid_dq_out got=%h exp=0", dq_out); end
    #10;
    ResetN = 1'b1;
    // first edge after release must accept the ACTIVE
    issue(C_ACT, 2'd0, 11'd0, 32'h0, 4'h0);
    issue(C_WR, 2'd0, 11'h005, 32'h5A5A0001, 4'h0);
    issue(C_RD, 2'd0, 11'h005, 32'h0, 4'h0);
    e.data = 32'h5A5A0001; e.at = last_edge + 1;
    sb.push_back(e);
    nop(4);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL post_rst_error got=%b exp=0", error); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL post_rst_drain got=%0d left exp=0", sb.size()); end
  endtask

  initial begin
    ResetN = 1'b0;
    cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1; cke = 1'b1;
    ba = 2'd0; addr = 11'h0; dm = 4'h0; dq_in = 32'h0;
    test_reset();
    test_basic();
    test_burst8();
    test_partial();
    test_terminate();
    test_errors();
    test_refresh();
    test_cke();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
